// File: rtl/serializer_pkg.sv
// Shared definitions for the bit serializer: FSM state encoding and the
// counter-width helper used to size the bit-period divider.
package serializer_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // A counter for n states needs $clog2(n) bits; n = 1 still gets one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bit_tick_gen.sv
// Bit-period divider: counts 0..DIV-1 while enabled and flags the last cycle
// of each bit period on tick.
module bit_tick_gen #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic tick
);
    import serializer_pkg::*;

    localparam int            DW   = cnt_width(DIV);
    localparam logic [DW-1:0] LAST = DW'(DIV - 1);

    logic [DW-1:0] cnt;

    // With DIV = 1 the counter never leaves 0, so every enabled cycle ticks.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

    assign tick = en && (cnt == LAST);

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: accepts a word on a valid/ready handshake and
// shifts it out one bit per DIV-cycle period, chaining frames with no gap.
module bit_serializer #(
    parameter int   WIDTH     = 8,
    parameter int   DIV       = 1,
    parameter int   MSB_FIRST = 0,
    parameter logic IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             dout,
    output logic             bit_valid,
    output logic             busy
);
    import serializer_pkg::*;

    localparam int            BW       = $clog2(WIDTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    state_t           state, state_n;
    logic [WIDTH-1:0] sreg, sreg_n;
    logic [BW-1:0]    bit_cnt, bit_cnt_n;
    logic             dout_n, bit_valid_n, busy_n;
    logic             tick, transfer, shifting;

    function automatic logic lead_bit(input logic [WIDTH-1:0] w);
        return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
    endfunction

    assign shifting = (state == SHIFT);
    // Ready in idle, or in the very last cycle of the final bit so the next
    // frame starts without a gap.
    assign in_ready = rst && (!shifting || (tick && (bit_cnt == LAST_BIT)));
    assign transfer = in_valid && in_ready;

    bit_tick_gen #(
        .DIV(DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clear(transfer),
        .en   (shifting),
        .tick (tick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            sreg      <= '0;
            bit_cnt   <= '0;
            dout      <= IDLE_BIT;
            bit_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            sreg      <= sreg_n;
            bit_cnt   <= bit_cnt_n;
            dout      <= dout_n;
            bit_valid <= bit_valid_n;
            busy      <= busy_n;
        end
    end

    // dout is registered, so each update loads the bit that appears next cycle.
    always_comb begin
        state_n     = state;
        sreg_n      = sreg;
        bit_cnt_n   = bit_cnt;
        dout_n      = IDLE_BIT;
        bit_valid_n = 1'b0;
        busy_n      = 1'b0;

        case (state)
            IDLE: begin
                state_n = IDLE;
            end
            SHIFT: begin
                dout_n = dout;
                busy_n = 1'b1;
                if (tick) begin
                    if (bit_cnt == LAST_BIT) begin
                        state_n   = IDLE;
                        bit_cnt_n = '0;
                        dout_n    = IDLE_BIT;
                        busy_n    = 1'b0;
                    end else begin
                        sreg_n      = (MSB_FIRST != 0) ? (sreg << 1) : (sreg >> 1);
                        bit_cnt_n   = bit_cnt + 1'b1;
                        dout_n      = lead_bit(sreg_n);
                        bit_valid_n = 1'b1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        if (transfer) begin
            state_n     = SHIFT;
            sreg_n      = in_data;
            bit_cnt_n   = '0;
            dout_n      = lead_bit(in_data);
            bit_valid_n = 1'b1;
            busy_n      = 1'b1;
        end
    end

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer: three instances cover LSB-first DIV=1,
// MSB-first DIV=3 and LSB-first DIV=2 with backpressure.
module tb_bit_serializer;

    logic clk;
    logic rst;

    logic       valid_a, in_ready_a, dout_a, bit_valid_a, busy_a;
    logic [7:0] data_a;
    logic       valid_b, in_ready_b, dout_b, bit_valid_b, busy_b;
    logic [7:0] data_b;
    logic       valid_c, in_ready_c, dout_c, bit_valid_c, busy_c;
    logic [7:0] data_c;

    int checks;
    int errors;

    bit_serializer #(.WIDTH(8), .DIV(1), .MSB_FIRST(0), .IDLE_BIT(1'b0)) u_a (
        .clk(clk), .rst(rst), .in_valid(valid_a), .in_data(data_a),
        .in_ready(in_ready_a), .dout(dout_a), .bit_valid(bit_valid_a), .busy(busy_a)
    );

    bit_serializer #(.WIDTH(8), .DIV(3), .MSB_FIRST(1), .IDLE_BIT(1'b0)) u_b (
        .clk(clk), .rst(rst), .in_valid(valid_b), .in_data(data_b),
        .in_ready(in_ready_b), .dout(dout_b), .bit_valid(bit_valid_b), .busy(busy_b)
    );

    bit_serializer #(.WIDTH(8), .DIV(2), .MSB_FIRST(0), .IDLE_BIT(1'b0)) u_c (
        .clk(clk), .rst(rst), .in_valid(valid_c), .in_data(data_c),
        .in_ready(in_ready_c), .dout(dout_c), .bit_valid(bit_valid_c), .busy(busy_c)
    );

    always #5 clk = ~clk;

    task automatic test_reset;
        repeat (2) @(negedge clk);
        checks++;
        if (in_ready_a !== 1'b0) begin errors++; $display("[TB] FAIL reset_in_ready got %b exp 0", in_ready_a); end
        checks++;
        if (dout_a !== 1'b0) begin errors++; $display("[TB] FAIL reset_dout got %b exp 0", dout_a); end
        checks++;
        if (busy_a !== 1'b0 || bit_valid_a !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_busy_bv got %b%b exp 00", busy_a, bit_valid_a);
        end
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (in_ready_a !== 1'b1 || dout_a !== 1'b0 || busy_a !== 1'b0) begin
                errors++;
                $display("[TB] FAIL idle[%0d] ready/dout/busy got %b%b%b exp 100", i, in_ready_a, dout_a, busy_a);
            end
        end
    endtask

    task automatic test_lsb_frame;
        logic [7:0] exp_seq;
        exp_seq = 8'b0000_1111;
        @(negedge clk);
        valid_a = 1'b1;
        data_a  = 8'hF0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            valid_a = 1'b0;
            checks++;
            if (dout_a !== exp_seq[7-i]) begin
                errors++; $display("[TB] FAIL lsb_dout[%0d] got %b exp %b", i, dout_a, exp_seq[7-i]);
            end
            checks++;
            if (bit_valid_a !== 1'b1 || busy_a !== 1'b1) begin
                errors++; $display("[TB] FAIL lsb_bv_busy[%0d] got %b%b exp 11", i, bit_valid_a, busy_a);
            end
            checks++;
            if (in_ready_a !== (i == 7)) begin
                errors++; $display("[TB] FAIL lsb_ready[%0d] got %b exp %b", i, in_ready_a, (i == 7));
            end
        end
        @(negedge clk);
        checks++;
        if (dout_a !== 1'b0 || busy_a !== 1'b0 || bit_valid_a !== 1'b0) begin
            errors++; $display("[TB] FAIL lsb_end dout/busy/bv got %b%b%b exp 000", dout_a, busy_a, bit_valid_a);
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] exp_seq;
        exp_seq = 16'b0000_1111_1111_0000;
        @(negedge clk);
        valid_a = 1'b1;
        data_a  = 8'hF0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (i == 0) data_a = 8'h0F;
            checks++;
            if (dout_a !== exp_seq[15-i]) begin
                errors++; $display("[TB] FAIL b2b_dout[%0d] got %b exp %b", i, dout_a, exp_seq[15-i]);
            end
            checks++;
            if (busy_a !== 1'b1 || bit_valid_a !== 1'b1) begin
                errors++; $display("[TB] FAIL b2b_busy_bv[%0d] got %b%b exp 11", i, busy_a, bit_valid_a);
            end
            checks++;
            if (in_ready_a !== (i == 7 || i == 15)) begin
                errors++; $display("[TB] FAIL b2b_ready[%0d] got %b exp %b", i, in_ready_a, (i == 7 || i == 15));
            end
            if (i == 8) valid_a = 1'b0;
        end
        @(negedge clk);
        checks++;
        if (dout_a !== 1'b0 || busy_a !== 1'b0) begin
            errors++; $display("[TB] FAIL b2b_end dout/busy got %b%b exp 00", dout_a, busy_a);
        end
    endtask

    task automatic test_msb_div3;
        logic [7:0] exp_seq;
        exp_seq = 8'b1010_0101;
        @(negedge clk);
        valid_b = 1'b1;
        data_b  = 8'hA5;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            valid_b = 1'b0;
            checks++;
            if (dout_b !== exp_seq[7-i/3]) begin
                errors++; $display("[TB] FAIL msb_dout[%0d] got %b exp %b", i, dout_b, exp_seq[7-i/3]);
            end
            checks++;
            if (bit_valid_b !== (i % 3 == 0)) begin
                errors++; $display("[TB] FAIL msb_bv[%0d] got %b exp %b", i, bit_valid_b, (i % 3 == 0));
            end
            checks++;
            if (busy_b !== 1'b1 || in_ready_b !== (i == 23)) begin
                errors++; $display("[TB] FAIL msb_busy_ready[%0d] got %b%b exp 1%b", i, busy_b, in_ready_b, (i == 23));
            end
        end
        @(negedge clk);
        checks++;
        if (dout_b !== 1'b0 || busy_b !== 1'b0) begin
            errors++; $display("[TB] FAIL msb_end dout/busy got %b%b exp 00", dout_b, busy_b);
        end
    endtask

    task automatic test_backpressure;
        logic [7:0] exp_a;
        logic [7:0] exp_b;
        exp_a = 8'b1000_0001;
        exp_b = 8'b0011_1100;
        @(negedge clk);
        valid_c = 1'b1;
        data_c  = 8'h81;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            checks++;
            if (dout_c !== exp_a[7-i/2]) begin
                errors++; $display("[TB] FAIL bp_a_dout[%0d] got %b exp %b", i, dout_c, exp_a[7-i/2]);
            end
            checks++;
            if (in_ready_c !== (i == 15)) begin
                errors++; $display("[TB] FAIL bp_a_ready[%0d] got %b exp %b", i, in_ready_c, (i == 15));
            end
            data_c = (i == 15) ? 8'h3C : (8'hC3 ^ 8'(i));
        end
        for (int j = 0; j < 16; j++) begin
            @(negedge clk);
            checks++;
            if (dout_c !== exp_b[7-j/2]) begin
                errors++; $display("[TB] FAIL bp_b_dout[%0d] got %b exp %b", j, dout_c, exp_b[7-j/2]);
            end
            checks++;
            if (bit_valid_c !== (j % 2 == 0) || busy_c !== 1'b1) begin
                errors++; $display("[TB] FAIL bp_b_bv_busy[%0d] got %b%b exp %b1", j, bit_valid_c, busy_c, (j % 2 == 0));
            end
            if (j == 15) valid_c = 1'b0;
            else         data_c  = 8'h5A ^ 8'(j);
        end
        @(negedge clk);
        checks++;
        if (dout_c !== 1'b0 || busy_c !== 1'b0) begin
            errors++; $display("[TB] FAIL bp_end dout/busy got %b%b exp 00", dout_c, busy_c);
        end
    endtask

    task automatic test_mid_reset;
        logic [7:0] exp_seq;
        exp_seq = 8'b1000_0000;
        @(negedge clk);
        valid_a = 1'b1;
        data_a  = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            valid_a = 1'b0;
            checks++;
            if (dout_a !== 1'b1) begin
                errors++; $display("[TB] FAIL mr_pre_dout[%0d] got %b exp 1", i, dout_a);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (dout_a !== 1'b0 || busy_a !== 1'b0 || bit_valid_a !== 1'b0) begin
            errors++; $display("[TB] FAIL mr_abort dout/busy/bv got %b%b%b exp 000", dout_a, busy_a, bit_valid_a);
        end
        checks++;
        if (in_ready_a !== 1'b0) begin
            errors++; $display("[TB] FAIL mr_ready_low got %b exp 0", in_ready_a);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready_a !== 1'b1 || busy_a !== 1'b0) begin
            errors++; $display("[TB] FAIL mr_release ready/busy got %b%b exp 10", in_ready_a, busy_a);
        end
        valid_a = 1'b1;
        data_a  = 8'h01;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            valid_a = 1'b0;
            checks++;
            if (dout_a !== exp_seq[7-i] || busy_a !== 1'b1) begin
                errors++; $display("[TB] FAIL mr_post[%0d] dout/busy got %b%b exp %b1", i, dout_a, busy_a, exp_seq[7-i]);
            end
        end
        @(negedge clk);
        checks++;
        if (dout_a !== 1'b0 || busy_a !== 1'b0) begin
            errors++; $display("[TB] FAIL mr_end dout/busy got %b%b exp 00", dout_a, busy_a);
        end
    endtask

    initial begin
        clk     = 1'b0;
        rst     = 1'b0;
        checks  = 0;
        errors  = 0;
        valid_a = 1'b0; data_a = '0;
        valid_b = 1'b0; data_b = '0;
        valid_c = 1'b0; data_c = '0;

        test_reset();
        test_lsb_frame();
        test_back_to_back();
        test_msb_div3();
        test_backpressure();
        test_mid_reset();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
